// File: rtl/cc_game_pkg.sv
// Shared definitions for the counter-chase game control blocks:
// turn FSM states, board/player limits and small helpers.
package cc_game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        PASS = 2'd2
    } state_t;

    localparam int MAX_PLAYERS    = 4;
    localparam int BOARD_LEN      = 24;
    localparam int DEFAULT_STEP_W = 3;

    // Effective player count: N when it is a legal 2..4, otherwise the maximum.
    function automatic logic [2:0] eff_players(input logic [4:0] n);
        if (n >= 5'd2 && n <= 5'd4) begin
            return n[2:0];
        end
        return 3'(MAX_PLAYERS);
    endfunction

    // One-hot advance-enable pattern for a player index.
    function automatic logic [3:0] player_onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Idle-cycle counter that flags an expired turn after TIMEOUT cycles in IDLE.
// Only instantiated when TURN_TIMEOUT_EN is defined.
module turn_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic B,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(TIMEOUT));

    // Count enabled cycles, saturating at TIMEOUT; clear has priority.
    always_ff @(posedge B or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/turn_ctrl.sv
// Turn controller: accepts move/miss requests for the active player, streams
// advance enables to that player's position counter, and rotates the turn.
// Optional feature: define TURN_TIMEOUT_EN to auto-pass after TIMEOUT idle cycles.
module turn_ctrl
    import cc_game_pkg::*;
#(
    parameter int          STEP_W  = DEFAULT_STEP_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              B,
    input  logic              rst,
    input  logic [4:0]        N,
    input  logic              move_req,
    input  logic              match,
    input  logic [STEP_W-1:0] steps,
    output logic              p_da1,
    output logic              p_da2,
    output logic              p_da3,
    output logic              p_da4,
    output logic [1:0]        cur_player,
    output logic              busy,
    output logic              turn_done
);

    state_t            state, next_state;
    logic [STEP_W-1:0] rem, rem_d;
    logic [3:0]        p_da, p_da_d;
    logic [1:0]        cur_d;
    logic              busy_d, done_d;
    logic              accept;
    logic              timer_expired;
    logic [2:0]        neff;
    logic [2:0]        cur_inc;
    logic [1:0]        next_player;

    assign accept  = move_req && (state == IDLE);
    assign neff    = eff_players(N);
    assign cur_inc = {1'b0, cur_player} + 3'd1;
    // Also wraps to 0 when N was lowered below the current player index.
    assign next_player = (cur_inc >= neff) ? 2'd0 : cur_inc[1:0];

`ifdef TURN_TIMEOUT_EN
    turn_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .B       (B),
        .rst     (rst),
        .clr     (accept || (state != IDLE)),
        .en      (state == IDLE),
        .expired (timer_expired)
    );
`else
    assign timer_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge B or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a real request wins over an idle timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!match) begin
                        next_state = PASS;
                    end else if (steps != '0) begin
                        next_state = MOVE;
                    end
                end else if (timer_expired) begin
                    next_state = PASS;
                end
            end
            MOVE: begin
                if (rem <= STEP_W'(1)) begin
                    next_state = IDLE;
                end
            end
            PASS:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs and the remaining-step count.
    always_comb begin
        p_da_d = 4'b0000;
        busy_d = (next_state != IDLE);
        done_d = 1'b0;
        cur_d  = cur_player;
        rem_d  = rem;
        case (state)
            IDLE: begin
                if (accept && match) begin
                    if (steps != '0) begin
                        rem_d  = steps;
                        p_da_d = player_onehot(cur_player);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            MOVE: begin
                if (rem <= STEP_W'(1)) begin
                    rem_d  = '0;
                    done_d = 1'b1;
                end else begin
                    rem_d  = rem - 1'b1;
                    p_da_d = player_onehot(cur_player);
                end
            end
            PASS: begin
                cur_d  = next_player;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers; reset aborts any move without a completion pulse.
    always_ff @(posedge B or posedge rst) begin
        if (rst) begin
            rem        <= '0;
            p_da       <= 4'b0000;
            cur_player <= 2'd0;
            busy       <= 1'b0;
            turn_done  <= 1'b0;
        end else begin
            rem        <= rem_d;
            p_da       <= p_da_d;
            cur_player <= cur_d;
            busy       <= busy_d;
            turn_done  <= done_d;
        end
    end

    assign p_da1 = p_da[0];
    assign p_da2 = p_da[1];
    assign p_da3 = p_da[2];
    assign p_da4 = p_da[3];

endmodule

// File: tb/tb_turn_ctrl.sv
// Directed bench for turn_ctrl: moves, passes, busy-ignore, N changes,
// asynchronous reset mid-move and the optional idle timeout.
module tb_turn_ctrl;

    logic       B = 1'b0;
    logic       rst;
    logic [4:0] N;
    logic       move_req;
    logic       match;
    logic [2:0] steps;
    logic       p_da1, p_da2, p_da3, p_da4;
    logic [1:0] cur_player;
    logic       busy;
    logic       turn_done;

    int passed = 0;
    int total  = 0;
    int da_cnt [4];
    int done_cnt;
    int multi_cnt;

    turn_ctrl dut (
        .B          (B),
        .rst        (rst),
        .N          (N),
        .move_req   (move_req),
        .match      (match),
        .steps      (steps),
        .p_da1      (p_da1),
        .p_da2      (p_da2),
        .p_da3      (p_da3),
        .p_da4      (p_da4),
        .cur_player (cur_player),
        .busy       (busy),
        .turn_done  (turn_done)
    );

    always #5 B = ~B;

    function automatic logic [3:0] pda();
        return {p_da4, p_da3, p_da2, p_da1};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge B);
        #1;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) da_cnt[i] = 0;
        done_cnt  = 0;
        multi_cnt = 0;
    endtask

    // Accumulate per-cycle activity and flag illegal enable patterns.
    task automatic observe();
        logic [3:0] pv;
        pv = pda();
        for (int i = 0; i < 4; i++) if (pv[i]) da_cnt[i]++;
        if ($countones(pv) > 1) multi_cnt++;
        if (!busy && pv != 4'b0000) multi_cnt++;
        if (turn_done) done_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            observe();
        end
    endtask

    task automatic req(input logic m, input logic [2:0] s);
        move_req = 1'b1;
        match    = m;
        steps    = s;
        tick();
        move_req = 1'b0;
        observe();
    endtask

    initial begin
        rst = 1'b1; N = 5'd4; move_req = 1'b0; match = 1'b0; steps = 3'd0;
        clr_counts();
        tick();
        check("rst_pda",  32'(pda()), 32'd0);
        check("rst_cur",  32'(cur_player), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(turn_done), 32'd0);
        rst = 1'b0;
        idle(2);

        // N=4, player 0 moves 3 squares
        clr_counts();
        req(1'b1, 3'd3);
        check("mv3_first_pda", 32'(pda()), 32'b0001);
        check("mv3_first_busy", 32'(busy), 32'd1);
        idle(2);
        check("mv3_third_pda", 32'(pda()), 32'b0001);
        idle(1);
        check("mv3_end_pda", 32'(pda()), 32'd0);
        check("mv3_end_done", 32'(turn_done), 32'd1);
        check("mv3_end_busy", 32'(busy), 32'd0);
        idle(2);
        check("mv3_da_cnt", 32'(da_cnt[0]), 32'd3);
        check("mv3_done_cnt", 32'(done_cnt), 32'd1);
        check("mv3_cur", 32'(cur_player), 32'd0);
        check("mv3_onehot", 32'(multi_cnt), 32'd0);

        // N=3, three misses rotate 0->1->2->0
        N = 5'd3;
        clr_counts();
        for (int k = 0; k < 3; k++) begin
            req(1'b0, 3'd0);
            check("pass_busy", 32'(busy), 32'd1);
            idle(2);
            check("pass_cur", 32'(cur_player), 32'((k + 1) % 3));
        end
        check("pass3_done_cnt", 32'(done_cnt), 32'd3);
        check("pass3_no_pda", 32'(da_cnt[0] + da_cnt[1] + da_cnt[2] + da_cnt[3]), 32'd0);

        // Request during a 7-step move is dropped
        clr_counts();
        req(1'b1, 3'd7);
        idle(2);
        req(1'b1, 3'd3);
        idle(10);
        check("busy_ign_da_cnt", 32'(da_cnt[0]), 32'd7);
        check("busy_ign_done", 32'(done_cnt), 32'd1);
        check("busy_ign_onehot", 32'(multi_cnt), 32'd0);

        // N=4: rotate to player 3, move drives p_da4
        N = 5'd4;
        for (int k = 0; k < 3; k++) begin
            req(1'b0, 3'd0);
            idle(2);
        end
        check("n4_cur3", 32'(cur_player), 32'd3);
        clr_counts();
        req(1'b1, 3'd2);
        check("p4_first_pda", 32'(pda()), 32'b1000);
        idle(4);
        check("p4_da_cnt", 32'(da_cnt[3]), 32'd2);
        check("p4_done_cnt", 32'(done_cnt), 32'd1);

        // N lowered to 2 while player 3 is active -> wraps to 0
        N = 5'd2;
        req(1'b0, 3'd0);
        idle(2);
        check("nred_cur", 32'(cur_player), 32'd0);

        // Zero-step match is a no-op that still completes
        clr_counts();
        req(1'b1, 3'd0);
        check("zero_done", 32'(turn_done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_pda", 32'(pda()), 32'd0);
        idle(2);
        check("zero_cur", 32'(cur_player), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd1);
        check("zero_no_pda", 32'(da_cnt[0] + da_cnt[1] + da_cnt[2] + da_cnt[3]), 32'd0);

        // Illegal N behaves as 4 players
        N = 5'd7;
        for (int k = 0; k < 3; k++) begin
            req(1'b0, 3'd0);
            idle(2);
        end
        check("nill_cur3", 32'(cur_player), 32'd3);
        req(1'b0, 3'd0);
        idle(2);
        check("nill_wrap", 32'(cur_player), 32'd0);

        // Reset mid-move after 2 enable cycles
        N = 5'd4;
        req(1'b0, 3'd0);
        idle(2);
        check("rstmv_cur1", 32'(cur_player), 32'd1);
        clr_counts();
        req(1'b1, 3'd5);
        idle(1);
        check("rstmv_pre_cnt", 32'(da_cnt[1]), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rstmv_pda", 32'(pda()), 32'd0);
        check("rstmv_cur", 32'(cur_player), 32'd0);
        check("rstmv_busy", 32'(busy), 32'd0);
        check("rstmv_done", 32'(turn_done), 32'd0);
        tick();
        rst = 1'b0;
        idle(8);
        check("rstmv_no_done", 32'(done_cnt), 32'd0);
        check("rstmv_da_cnt", 32'(da_cnt[1]), 32'd2);

        // Idle behaviour with no requests
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_counts();
`ifdef TURN_TIMEOUT_EN
        idle(250);
        check("to_early_done", 32'(done_cnt), 32'd0);
        check("to_early_cur", 32'(cur_player), 32'd0);
        idle(10);
        check("to_done", 32'(done_cnt), 32'd1);
        check("to_cur", 32'(cur_player), 32'd1);
        check("to_no_pda", 32'(da_cnt[0] + da_cnt[1] + da_cnt[2] + da_cnt[3]), 32'd0);
`else
        idle(1000);
        check("noto_cur", 32'(cur_player), 32'd0);
        check("noto_done", 32'(done_cnt), 32'd0);
        check("noto_busy", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
